dmem_responder: RTL and testbench

//  Data-memory responder at the memory stage of the pipelined RISC-V core.

---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the M stage of the pipeline and the data
// memory responder.
//   master (pipeline side) drives : MemReqM, MemWriteM, ALUResult_M,
//                                   WriteDataM, ByteEnM
//   slave  (responder side) drives: ReadData, StallM, RespM, MisalignM
// ----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUResult_M;
  logic [31:0] WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadData;
  logic        StallM;
  logic        RespM;
  logic        MisalignM;

  modport master (
    output MemReqM, MemWriteM, ALUResult_M, WriteDataM, ByteEnM,
    input  ReadData, StallM, RespM, MisalignM
  );

  modport slave (
    input  MemReqM, MemWriteM, ALUResult_M, WriteDataM, ByteEnM,
    output ReadData, StallM, RespM, MisalignM
  );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the M stage. Each load/store is held for a fixed
// LATENCY cycles (StallM freezes F/D/E/M), the array is accessed on the edge
// entering RESP, and RespM pulses for one cycle while the pipeline advances.
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-low
//   bus    : dmem_responder_if.slave (request in, ReadData/StallM/RespM/
//            MisalignM out)
// Parameters: DEPTH_WORDS (power of two, >= 2), LATENCY (1..15).
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;

  // Latched request, used while in WAIT
  logic [AW+1:0]    r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;
  logic [3:0]       r_be;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rdata;
  logic             r_resp;
  logic             r_misalign;

  // Request actually used by the access (live inputs when LATENCY==1)
  logic [AW+1:0]    w_addr;
  logic [31:0]      w_wdata;
  logic             w_we;
  logic [3:0]       w_be;
  logic             w_mis;
  logic [AW-1:0]    w_idx;
  logic             w_access;

  // State and countdown register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and countdown logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.MemReqM) begin
          w_cnt_next   = 4'(LATENCY - 1);
          w_state_next = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
        end else begin
          w_state_next = WAIT;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Capture the request in its IDLE cycle; inputs are ignored afterwards
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
    end else if ((r_state == IDLE) && bus.MemReqM) begin
      r_addr  <= bus.ALUResult_M[AW+1:0];
      r_wdata <= bus.WriteDataM;
      r_we    <= bus.MemWriteM;
      r_be    <= bus.ByteEnM;
    end
  end

  // Select live inputs in IDLE (LATENCY==1 accesses straight from IDLE)
  always_comb begin
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_we    = r_we;
    w_be    = r_be;
    if (r_state == IDLE) begin
      w_addr  = bus.ALUResult_M[AW+1:0];
      w_wdata = bus.WriteDataM;
      w_we    = bus.MemWriteM;
      w_be    = bus.ByteEnM;
    end else begin
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_we    = r_we;
      w_be    = r_be;
    end
  end

  // Upper address bits are dropped, so addresses wrap modulo DEPTH_WORDS*4
  assign w_idx    = w_addr[AW+1:2];
  assign w_mis    = |w_addr[1:0];
  assign w_access = (w_state_next == RESP) && (r_state != RESP);

  // Array write with byte lanes; contents survive reset, and reset during
  // the access edge suppresses the write
  always_ff @(posedge clk) begin
    if (reset && w_access && w_we && !w_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered response: ReadData holds until the next load or misaligned access
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata    <= 32'd0;
      r_resp     <= 1'b0;
      r_misalign <= 1'b0;
    end else if (w_access) begin
      r_resp     <= 1'b1;
      r_misalign <= w_mis;
      if (w_mis) begin
        r_rdata <= 32'd0;
      end else if (!w_we) begin
        r_rdata <= r_mem[w_idx];
      end
    end else if (r_state == RESP) begin
      r_resp     <= 1'b0;
      r_misalign <= 1'b0;
    end
  end

  // StallM follows MemReqM combinationally so the requesting cycle is held;
  // gated by reset so nothing stalls while reset is asserted
  assign bus.StallM    = reset &&
                         (((r_state == IDLE) && bus.MemReqM) || (r_state == WAIT));
  assign bus.ReadData  = r_rdata;
  assign bus.RespM     = r_resp;
  assign bus.MisalignM = r_misalign;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
// Each request pushes its expected response (ReadData, MisalignM) onto a
// scoreboard queue computed from a reference memory model; responses are
// popped and compared when RespM is seen.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        reset;
  exp_t        sb_q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] m_rdata;
  int          checks;
  int          failures;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model update plus scoreboard push for one access
  task automatic model_push(input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    exp_t        e;
    logic [7:0]  idx;
    idx = addr[9:2];
    if (addr[1:0] != 2'b00) begin
      m_rdata = 32'd0;
      e.mis   = 1'b1;
    end else begin
      e.mis = 1'b0;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
        end
      end else begin
        m_rdata = mdl[idx];
      end
    end
    e.rdata = m_rdata;
    sb_q.push_back(e);
  endtask

  // Called right at a falling edge with the DUT in IDLE; returns in the RESP cycle
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    int   stalls;
    int   c;
    bit   got;
    exp_t e;
    bus.MemReqM     = 1'b1;
    bus.MemWriteM   = we;
    bus.ALUResult_M = addr;
    bus.WriteDataM  = data;
    bus.ByteEnM     = be;
    model_push(we, addr, data, be);
    stalls = 0;
    c      = 0;
    got    = 1'b0;
    #1;
    check({tag, "_first_stall"}, 32'(bus.StallM), 32'd1);
    while (!got && c < 20) begin
      if (bus.RespM === 1'b1) begin
        got = 1'b1;
        check({tag, "_stall_in_resp"}, 32'(bus.StallM), 32'd0);
        check({tag, "_stall_count"}, 32'(stalls), 32'(LAT));
        if (sb_q.size() == 0) begin
          check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_rdata"}, bus.ReadData, e.rdata);
          check({tag, "_misalign"}, 32'(bus.MisalignM), 32'(e.mis));
        end
      end else begin
        if (bus.StallM === 1'b1) stalls++;
        @(negedge clk);
        bus.MemReqM = 1'b0;
        c++;
        #1;
      end
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    checks   = 0;
    failures = 0;
    m_rdata  = 32'd0;
    reset            = 1'b0;
    bus.MemReqM      = 1'b1;
    bus.MemWriteM    = 1'b0;
    bus.ALUResult_M  = 32'd0;
    bus.WriteDataM   = 32'd0;
    bus.ByteEnM      = 4'd0;

    // Reset held with a pending request: nothing stalls or responds
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_stall", 32'(bus.StallM), 32'd0);
      check("rst_resp", 32'(bus.RespM), 32'd0);
      check("rst_rdata", bus.ReadData, 32'd0);
    end
    @(negedge clk);
    reset       = 1'b1;
    bus.MemReqM = 1'b0;
    #1;
    check("idle_no_req_stall", 32'(bus.StallM), 32'd0);
    check("idle_misalign", 32'(bus.MisalignM), 32'd0);

    // Full-word store then load
    @(negedge clk); access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk); access("ld10", 1'b0, 32'h10, 32'h0, 4'h0);

    // Partial store over existing word
    @(negedge clk); access("st20", 1'b1, 32'h20, 32'h11223344, 4'hF);
    @(negedge clk); access("st20p", 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
    @(negedge clk); access("ld20", 1'b0, 32'h20, 32'h0, 4'h0);

    // Misaligned load and store leave the word intact
    @(negedge clk); access("ld23mis", 1'b0, 32'h23, 32'h0, 4'h0);
    @(negedge clk); access("st21mis", 1'b1, 32'h21, 32'hFFFFFFFF, 4'hF);
    @(negedge clk); access("ld20b", 1'b0, 32'h20, 32'h0, 4'h0);

    // Address wrap with back-to-back accesses (no idle bubble)
    @(negedge clk); access("st400", 1'b1, 32'h400, 32'h5A5A1234, 4'hF);
    @(negedge clk); access("ld0_b2b", 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset during WAIT of a store abandons it
    @(negedge clk); access("st40", 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    bus.MemReqM     = 1'b1;
    bus.MemWriteM   = 1'b1;
    bus.ALUResult_M = 32'h40;
    bus.WriteDataM  = 32'h12345678;
    bus.ByteEnM     = 4'hF;
    @(negedge clk);
    reset       = 1'b0;
    bus.MemReqM = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_stall", 32'(bus.StallM), 32'd0);
    check("midrst_resp", 32'(bus.RespM), 32'd0);
    check("midrst_rdata", bus.ReadData, 32'd0);
    m_rdata = 32'd0;
    reset   = 1'b1;
    @(negedge clk); access("ld40", 1'b0, 32'h40, 32'h0, 4'h0);

    // A few random aligned store/load pairs
    for (int i = 0; i < 4; i++) begin
      ra = 32'($urandom_range(0, 255)) << 2;
      rd = $urandom;
      @(negedge clk); access("rnd_st", 1'b1, ra, rd, 4'hF);
      @(negedge clk); access("rnd_ld", 1'b0, ra, 32'h0, 4'h0);
    end

    @(negedge clk);
    #1;
    check("resp_cleared", 32'(bus.RespM), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
